// File: rtl/exe_stage_pipe_pkg.sv
// rtl/exe_stage_pipe_pkg.sv - shared opcodes, shift types, flag indices and FSM states for the execute stage
package exe_pkg;

  // ALU opcodes carried on exe_cmd
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  // Register-operand shift types in shift_operand[6:5]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Bit positions inside the {N,Z,C,V} status register
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // Sequencer states: single-cycle ALU path vs. iterative multiply
  typedef enum logic [0:0] {
    FSM_IDLE = 1'b0,
    FSM_MUL  = 1'b1
  } exe_state_e;

  // Opcodes outside this set produce 0 and never touch the flags
  function automatic logic cmd_defined(input logic [3:0] c);
    return (c >= CMD_MOV) && (c <= CMD_MLA);
  endfunction

  function automatic logic cmd_is_mul(input logic [3:0] c);
    return (c == CMD_MUL) || (c == CMD_MLA);
  endfunction

endpackage

// File: rtl/exe_stage_pipe_if.sv
// rtl/exe_stage_pipe_if.sv - instruction-in / result-out bundle of the execute stage
interface exe_stage_pipe_if #(
  parameter int DW   = 32,
  parameter int RA_W = 4
);
  // upstream (ID/EXE) side
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic            wb_en;
  logic            mem_r_en;
  logic            mem_w_en;
  logic            b;
  logic            s;
  logic            i;
  logic [3:0]      exe_cmd;
  logic [DW-1:0]   pc;
  logic [DW-1:0]   val_rn;
  logic [DW-1:0]   val_rm;
  logic [DW-1:0]   val_ra;
  logic [11:0]     shift_operand;
  logic [23:0]     imm24;
  logic [RA_W-1:0] dest;

  // downstream (EXE/MEM) side
  logic            out_valid;
  logic            out_ready;
  logic            wb_en_o;
  logic            mem_r_en_o;
  logic            mem_w_en_o;
  logic            branch_taken_o;
  logic [DW-1:0]   alu_res_o;
  logic [DW-1:0]   val_rm_o;
  logic [DW-1:0]   branch_addr_o;
  logic [RA_W-1:0] dest_o;
  logic [3:0]      status_o;

  modport master (
    output in_valid, flush, wb_en, mem_r_en, mem_w_en, b, s, i, exe_cmd,
           pc, val_rn, val_rm, val_ra, shift_operand, imm24, dest, out_ready,
    input  in_ready, out_valid, wb_en_o, mem_r_en_o, mem_w_en_o, branch_taken_o,
           alu_res_o, val_rm_o, branch_addr_o, dest_o, status_o
  );

  modport slave (
    input  in_valid, flush, wb_en, mem_r_en, mem_w_en, b, s, i, exe_cmd,
           pc, val_rn, val_rm, val_ra, shift_operand, imm24, dest, out_ready,
    output in_ready, out_valid, wb_en_o, mem_r_en_o, mem_w_en_o, branch_taken_o,
           alu_res_o, val_rm_o, branch_addr_o, dest_o, status_o
  );
endinterface

// File: rtl/exe_stage_pipe_mul_iter.sv
// rtl/exe_stage_pipe_mul_iter.sv - iterative shift-add multiplier retiring BPC multiplier bits per cycle
module exe_mul_iter #(
  parameter int DW  = 32,
  parameter int BPC = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          ack_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] acc_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] prod_o
);
  localparam int N  = DW / BPC;
  localparam int CW = $clog2(N + 1);

  logic [DW-1:0] mcand_q;
  logic [DW-1:0] mplr_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_step;
  logic [CW-1:0] cnt_q;
  logic          active_q;

  // One digit of the multiplier: add the shifted multiplicand for each set bit
  always_comb begin
    acc_step = acc_q;
    for (int j = 0; j < BPC; j++) begin
      if (mplr_q[j]) acc_step = acc_step + (mcand_q << j);
    end
  end

  // Abort wins over everything; the result is held until the owner acknowledges it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (abort_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplr_q   <= b_i;
      acc_q    <= acc_i;
      cnt_q    <= CW'(N);
      active_q <= 1'b1;
    end else if (active_q && (cnt_q != '0)) begin
      acc_q   <= acc_step;
      mcand_q <= mcand_q << BPC;
      mplr_q  <= mplr_q >> BPC;
      cnt_q   <= cnt_q - CW'(1);
    end else if (ack_i) begin
      active_q <= 1'b0;
    end
  end

  assign busy_o = active_q && (cnt_q != '0);
  assign done_o = active_q && (cnt_q == '0);
  assign prod_o = acc_q;
endmodule

// File: rtl/exe_stage_pipe.sv
// rtl/exe_stage_pipe.sv - handshaked execute stage with ALU, shifter, branch target and iterative multiply
module exe_stage_pipe #(
  parameter int DW      = 32,
  parameter int RA_W    = 4,
  parameter int MUL_BPC = 4
) (
  input logic             clk,
  input logic             rst,
  exe_stage_pipe_if.slave bus
);
  import exe_pkg::*;

  localparam logic [0:0] S_IDLE = FSM_IDLE;
  localparam logic [0:0] S_MUL  = FSM_MUL;

  function automatic logic [DW-1:0] ror_dw(input logic [DW-1:0] x, input int unsigned amt);
    int unsigned sh;
    sh = amt % DW;
    return (x >> sh) | (x << (DW - sh));
  endfunction

  // Operand 2: memory offset, rotated immediate, or shifted register
  function automatic logic [DW-1:0] calc_val2(input logic mem, input logic imm,
                                              input logic [11:0] so, input logic [DW-1:0] rm);
    logic [DW-1:0] r;
    int unsigned   sh;
    r  = '0;
    sh = 0;
    if (mem) begin
      r = {{(DW-12){1'b0}}, so};
    end else if (imm) begin
      sh = int'(so[11:8]) * 2;
      r  = ror_dw({{(DW-8){1'b0}}, so[7:0]}, sh);
    end else begin
      sh = int'(so[11:7]);
      case (so[6:5])
        SH_LSL:  r = rm << sh;
        SH_LSR:  r = rm >> sh;
        SH_ASR:  r = $signed(rm) >>> sh;
        default: r = ror_dw(rm, sh);
      endcase
    end
    return r;
  endfunction

  // Returns {C, V, result}; C and V pass through unless the op is arithmetic
  function automatic logic [DW+1:0] alu(input logic [3:0] cmd, input logic [DW-1:0] a,
                                        input logic [DW-1:0] v2, input logic c_in, input logic v_in);
    logic [DW:0]   sum;
    logic [DW-1:0] r;
    logic          c;
    logic          v;
    sum = '0;
    r   = '0;
    c   = c_in;
    v   = v_in;
    case (cmd)
      CMD_MOV: r = v2;
      CMD_MVN: r = ~v2;
      CMD_AND: r = a & v2;
      CMD_ORR: r = a | v2;
      CMD_EOR: r = a ^ v2;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, a} + {1'b0, v2} + {{DW{1'b0}}, (cmd == CMD_ADC) & c_in};
        r   = sum[DW-1:0];
        c   = sum[DW];
        v   = (a[DW-1] == v2[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      CMD_SUB, CMD_SBC: begin
        // a - b - borrow == a + ~b + carry_in, carry out is the not-borrow
        sum = {1'b0, a} + {1'b0, ~v2} + {{DW{1'b0}}, (cmd == CMD_SUB) | c_in};
        r   = sum[DW-1:0];
        c   = sum[DW];
        v   = (a[DW-1] != v2[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  logic [0:0]      state_q, state_d;
  logic            out_valid_q;
  logic            wb_en_q, mem_r_en_q, mem_w_en_q, branch_taken_q;
  logic [DW-1:0]   alu_res_q, val_rm_q, branch_addr_q;
  logic [RA_W-1:0] dest_q;
  logic [3:0]      status_q;

  // instruction fields parked while the multiplier iterates
  logic            p_wb_q, p_mem_r_q, p_mem_w_q, p_b_q, p_s_q;
  logic [DW-1:0]   p_rm_q, p_baddr_q;
  logic [RA_W-1:0] p_dest_q;

  logic            out_free, in_ready, accept, is_mul;
  logic            mul_start, mul_busy, mul_done, load_alu, load_mul, load, status_we;
  logic [DW-1:0]   val2, baddr_c, mul_prod;
  logic [DW+1:0]   alu_out;
  logic [DW+25:0]  off_ext;

  // result and its sideband, selected between the direct ALU path and a finished multiply
  logic            n_wb, n_mem_r, n_mem_w, n_b;
  logic [DW-1:0]   n_res, n_rm, n_baddr;
  logic [RA_W-1:0] n_dest;
  logic [3:0]      n_flags;

  assign is_mul    = cmd_is_mul(bus.exe_cmd);
  assign out_free  = !out_valid_q || bus.out_ready;
  assign in_ready  = !bus.flush && (state_q == S_IDLE) && !mul_busy && out_free;
  assign accept    = bus.in_valid && in_ready;
  assign mul_start = accept && is_mul;
  assign load_alu  = accept && !is_mul;
  assign load_mul  = !bus.flush && (state_q == S_MUL) && mul_done && out_free;
  assign load      = load_alu || load_mul;

  assign val2    = calc_val2(bus.mem_r_en | bus.mem_w_en, bus.i, bus.shift_operand, bus.val_rm);
  assign alu_out = alu(bus.exe_cmd, bus.val_rn, val2, status_q[C_BIT], status_q[V_BIT]);
  assign off_ext = {{DW{bus.imm24[23]}}, bus.imm24, 2'b00};
  assign baddr_c = bus.pc + off_ext[DW-1:0];

  exe_mul_iter #(
    .DW  (DW),
    .BPC (MUL_BPC)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .abort_i (bus.flush),
    .ack_i   (load_mul),
    .a_i     (bus.val_rn),
    .b_i     (bus.val_rm),
    .acc_i   ((bus.exe_cmd == CMD_MLA) ? bus.val_ra : '0),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Pick what enters the output register this edge and whether the flags follow it
  always_comb begin
    n_wb      = bus.wb_en;
    n_mem_r   = bus.mem_r_en;
    n_mem_w   = bus.mem_w_en;
    n_b       = bus.b;
    n_res     = alu_out[DW-1:0];
    n_rm      = bus.val_rm;
    n_baddr   = baddr_c;
    n_dest    = bus.dest;
    n_flags   = {alu_out[DW-1], alu_out[DW-1:0] == '0, alu_out[DW+1], alu_out[DW]};
    status_we = load_alu && bus.s && cmd_defined(bus.exe_cmd);
    if (load_mul) begin
      n_wb      = p_wb_q;
      n_mem_r   = p_mem_r_q;
      n_mem_w   = p_mem_w_q;
      n_b       = p_b_q;
      n_res     = mul_prod;
      n_rm      = p_rm_q;
      n_baddr   = p_baddr_q;
      n_dest    = p_dest_q;
      n_flags   = {mul_prod[DW-1], mul_prod == '0, status_q[C_BIT], status_q[V_BIT]};
      status_we = p_s_q;
    end
  end

  // Sequencer: leave IDLE only for a multiply, return once its result is registered
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE) begin
      if (mul_start) state_d = S_MUL;
    end else if (load_mul) begin
      state_d = S_IDLE;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Park the multiply's sideband fields at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_wb_q    <= 1'b0;
      p_mem_r_q <= 1'b0;
      p_mem_w_q <= 1'b0;
      p_b_q     <= 1'b0;
      p_s_q     <= 1'b0;
      p_rm_q    <= '0;
      p_baddr_q <= '0;
      p_dest_q  <= '0;
    end else if (mul_start) begin
      p_wb_q    <= bus.wb_en;
      p_mem_r_q <= bus.mem_r_en;
      p_mem_w_q <= bus.mem_w_en;
      p_b_q     <= bus.b;
      p_s_q     <= bus.s;
      p_rm_q    <= bus.val_rm;
      p_baddr_q <= baddr_c;
      p_dest_q  <= bus.dest;
    end
  end

  // EXE/MEM output register and status; flush only drops valid, data and flags hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      wb_en_q        <= 1'b0;
      mem_r_en_q     <= 1'b0;
      mem_w_en_q     <= 1'b0;
      branch_taken_q <= 1'b0;
      alu_res_q      <= '0;
      val_rm_q       <= '0;
      branch_addr_q  <= '0;
      dest_q         <= '0;
      status_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q    <= 1'b1;
      wb_en_q        <= n_wb;
      mem_r_en_q     <= n_mem_r;
      mem_w_en_q     <= n_mem_w;
      branch_taken_q <= n_b;
      alu_res_q      <= n_res;
      val_rm_q       <= n_rm;
      branch_addr_q  <= n_baddr;
      dest_q         <= n_dest;
      if (status_we) status_q <= n_flags;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.wb_en_o        = wb_en_q;
  assign bus.mem_r_en_o     = mem_r_en_q;
  assign bus.mem_w_en_o     = mem_w_en_q;
  assign bus.branch_taken_o = branch_taken_q;
  assign bus.alu_res_o      = alu_res_q;
  assign bus.val_rm_o       = val_rm_q;
  assign bus.branch_addr_o  = branch_addr_q;
  assign bus.dest_o         = dest_q;
  assign bus.status_o       = status_q;
endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb/tb_exe_stage_pipe.sv - directed self-checking bench for exe_stage_pipe
module tb_exe_stage_pipe;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lowcnt;
  int   seen;

  exe_stage_pipe_if #(.DW(32), .RA_W(4)) bus ();

  exe_stage_pipe #(.DW(32), .RA_W(4), .MUL_BPC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                    input logic [31:0] ra, input logic [11:0] so, input logic imm, input logic sf);
    bus.exe_cmd       = cmd;
    bus.val_rn        = rn;
    bus.val_rm        = rm;
    bus.val_ra        = ra;
    bus.shift_operand = so;
    bus.i             = imm;
    bus.s             = sf;
    bus.in_valid      = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.in_valid = 0; bus.flush = 0; bus.wb_en = 0; bus.mem_r_en = 0; bus.mem_w_en = 0;
    bus.b = 0; bus.s = 0; bus.i = 0; bus.exe_cmd = 0; bus.pc = 0; bus.val_rn = 0;
    bus.val_rm = 0; bus.val_ra = 0; bus.shift_operand = 0; bus.imm24 = 0; bus.dest = 0;
    bus.out_ready = 1;
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_status", bus.status_o, 0);
    chk("rst_alu_res", bus.alu_res_o, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // ADD overflow into the sign bit
    bus.dest = 4'h3; bus.wb_en = 1;
    op(4'b0010, 32'h7FFF_FFFF, 0, 0, 12'h001, 1, 1);
    tick();
    chk("add_valid", bus.out_valid, 1);
    chk("add_res", bus.alu_res_o, 32'h8000_0000);
    chk("add_status", bus.status_o, 4'b1001);
    chk("add_dest", bus.dest_o, 4'h3);
    chk("add_wb", bus.wb_en_o, 1);

    // undefined opcode with s=1: zero result, flags kept
    op(4'b0000, 5, 5, 0, 12'h000, 0, 1);
    tick();
    chk("undef_res", bus.alu_res_o, 0);
    chk("undef_status", bus.status_o, 4'b1001);

    // SUB to zero then ADC consuming the carry, back to back
    op(4'b0100, 5, 5, 0, 12'h000, 0, 1);
    tick();
    chk("sub_res", bus.alu_res_o, 0);
    chk("sub_status", bus.status_o, 4'b0110);
    chk("sub_in_ready", bus.in_ready, 1);
    op(4'b0011, 1, 0, 0, 12'h001, 1, 1);
    tick();
    chk("adc_res", bus.alu_res_o, 3);
    chk("adc_status", bus.status_o, 4'b0000);

    // MOV of register ASR #4 and of rotated immediate
    op(4'b0001, 0, 32'h8000_0000, 0, 12'h240, 0, 0);
    tick();
    chk("mov_asr", bus.alu_res_o, 32'hF800_0000);
    op(4'b0001, 0, 0, 0, 12'h4FF, 1, 0);
    tick();
    chk("mov_rotimm", bus.alu_res_o, 32'hFF00_0000);

    // memory address: zero-extended 12-bit offset regardless of i
    bus.mem_r_en = 1;
    op(4'b0010, 32'h1000, 0, 0, 12'hFFF, 0, 0);
    tick();
    chk("mem_addr", bus.alu_res_o, 32'h1FFF);
    chk("mem_r_en_o", bus.mem_r_en_o, 1);
    bus.mem_r_en = 0;

    // set C=1 for the multiply flag check
    op(4'b0100, 5, 0, 0, 12'h003, 1, 1);
    tick();
    chk("sub2_res", bus.alu_res_o, 2);
    chk("sub2_status", bus.status_o, 4'b0010);

    // MUL 0x1234 * 0x10
    op(4'b1010, 32'h1234, 32'h10, 0, 12'h000, 0, 1);
    tick();
    bus.in_valid = 0;
    chk("mul_no_early", bus.out_valid, 0);
    lowcnt = 0;
    for (int k = 0; k < 30 && bus.out_valid !== 1'b1; k++) begin
      if (bus.in_ready === 1'b0) lowcnt++;
      tick();
    end
    chk("mul_stall_cycles", lowcnt, 9);
    chk("mul_valid", bus.out_valid, 1);
    chk("mul_res", bus.alu_res_o, 32'h12340);
    chk("mul_status", bus.status_o, 4'b0010);

    // back-pressure: MUL result held, new ADD waits
    bus.out_ready = 0;
    op(4'b0010, 10, 0, 0, 12'h005, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_res", bus.alu_res_o, 32'h12340);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    tick();
    chk("bp_next_res", bus.alu_res_o, 15);
    chk("bp_next_valid", bus.out_valid, 1);
    bus.in_valid = 0;
    tick();
    chk("bp_drain", bus.out_valid, 0);

    // MLA 3*4+5, no flag update
    op(4'b1011, 3, 4, 5, 12'h000, 0, 0);
    tick();
    bus.in_valid = 0;
    for (int k = 0; k < 30 && bus.out_valid !== 1'b1; k++) tick();
    chk("mla_res", bus.alu_res_o, 17);
    tick();

    // flush during an MLA whose result would set Z
    op(4'b1011, 32'h1000_0000, 32'h10, 0, 12'h000, 0, 1);
    tick();
    bus.in_valid = 0;
    tick(); tick();
    bus.flush = 1;
    op(4'b0010, 1, 0, 0, 12'h001, 1, 0);
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    tick();
    bus.flush = 0;
    chk("flush_valid", bus.out_valid, 0);
    #1;
    chk("post_flush_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
    chk("post_flush_res", bus.alu_res_o, 2);
    chk("post_flush_valid", bus.out_valid, 1);
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("flush_no_stale", seen, 0);
    chk("flush_status", bus.status_o, 4'b0010);

    // branch with negative offset
    bus.b = 1; bus.pc = 32'h100; bus.imm24 = 24'hFFFFFE; bus.dest = 4'hA;
    op(4'b0001, 0, 0, 0, 12'h0AB, 1, 0);
    tick();
    bus.b = 0;
    chk("br_addr", bus.branch_addr_o, 32'hF8);
    chk("br_taken", bus.branch_taken_o, 1);
    chk("br_res", bus.alu_res_o, 32'hAB);

    // asynchronous reset in the middle of a multiply
    op(4'b1010, 7, 9, 0, 12'h000, 0, 1);
    tick();
    bus.in_valid = 0;
    tick(); tick();
    rst = 1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_res", bus.alu_res_o, 0);
    chk("arst_baddr", bus.branch_addr_o, 0);
    chk("arst_taken", bus.branch_taken_o, 0);
    chk("arst_dest", bus.dest_o, 0);
    chk("arst_status", bus.status_o, 0);
    tick(); tick();
    rst = 0;
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("arst_no_stale", seen, 0);
    chk("arst_in_ready", bus.in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exe_stage_pipe.md
# exe_stage_pipe

Parametrised, handshaked execute stage: computes the shifter operand, ALU result and NZCV status, plus the branch target, for one instruction at a time. Adds an iterative multi-cycle multiplier (MUL/MLA), valid/ready flow control, and a flush that aborts in-flight work. Sits between the ID/EXE register and the MEM stage, and registers its own outputs as the EXE/MEM boundary.

## Interface
- `DW`, 32: datapath width; power of two, at least 16.
- `RA_W`, 4: destination register index width.
- `MUL_BPC`, 4: multiplier bits retired per cycle; must divide `DW`. `N = DW/MUL_BPC`.
- `clk` in 1: clock. Ports run on the single clock `clk`.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: an instruction is presented on the inputs.
- `in_ready` out 1: the stage accepts that instruction at this edge.
- `flush` in 1: kill the registered output and any in-flight multiply.
- `wb_en`, `mem_r_en`, `mem_w_en`, `b`, `s`, `i` in 1 each: control bits. `i` means an immediate operand.
- `exe_cmd` in 4: ALU opcode.
- `pc`, `val_rn`, `val_rm`, `val_ra` in `DW` each. `val_ra` is the MLA accumulator.
- `shift_operand` in 12: operand-2 encoding.
- `imm24` in 24: branch offset in words.
- `dest` in `RA_W`: destination register index.
- `out_valid` out 1: the output register holds a result.
- `out_ready` in 1: the MEM stage accepts the result.
- `wb_en_o`, `mem_r_en_o`, `mem_w_en_o`, `branch_taken_o` out 1 each.
- `alu_res_o`, `val_rm_o`, `branch_addr_o` out `DW` each.
- `dest_o` out `RA_W`.
- `status_o` out 4: NZCV register, bit order `{N,Z,C,V}`.

## Operation
**Val2 (operand 2)**
- If `mem_r_en|mem_w_en`: zero-extended `shift_operand[11:0]`.
- Else if `i`: the 8-bit field `shift_operand[7:0]` rotated right within `DW` by `2*shift_operand[11:8]`.
- Else: `val_rm` shifted by amount `shift_operand[11:7]`, type `shift_operand[6:5]` (LSL, LSR, ASR, ROR).

**ALU commands (`exe_cmd`)**
- MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
- MUL 1010: `rn*rm`. MLA 1011: `rn*rm + ra`.
- Undefined codes: result 0, flags unchanged.
- ADC adds `status_o.C`; SBC subtracts `!C`.

**Flags**
- N = result MSB; Z = result equals 0.
- C and V come from ADD/ADC/SUB/SBC, with C = carry out and C = not-borrow for subtract.
- Logical ops, MOV/MVN and MUL/MLA keep C and V.
- Products are truncated to the low `DW` bits.

**Branch**
- `branch_taken_o` = registered `b`.
- `branch_addr_o` = `pc + (sign-extend(imm24) << 2)`, modulo 2^DW.

**Status register**
- Loads the new flags at the edge the result enters the output register, only if `s=1`.
- Never loads on flush.

**FSM**
- IDLE
  - `in_ready = !out_valid || out_ready`.
  - On accept of a non-multiply op: register the result and go to IDLE.
  - On accept of MUL/MLA: latch operands, `cnt = N`, go to MUL.
- MUL
  - `in_ready = 0`.
  - While `cnt > 0`: one iteration per edge, then decrement `cnt`.
  - At `cnt = 0`: when `!out_valid || out_ready`, register the result and go to IDLE; otherwise wait.

**Output register**
- `out_valid` clears on `out_ready` unless a new result is loaded at the same edge.
- All outputs hold stable while `out_valid && !out_ready`.

**Flush (highest priority)**
- `out_valid = 0`, FSM goes to IDLE, the counter clears, status is unchanged.
- `in_ready` is forced to 0 that cycle, so an instruction presented with `flush` is dropped.

## Timing
**Reset values**
- `out_valid`, all `*_o` data/control outputs, `status_o`: 0.
- FSM = IDLE, `cnt = 0`.
- `in_ready` = 1 after reset.

**Latency**
- ALU op accepted at edge k: `out_valid` = 1 after edge k.
- Multiply accepted at edge k: result registered at edge k+N+1 at the earliest; no result is registered at k.

**Throughput and ordering**
- One ALU op per cycle under continuous `out_ready`.
- An op accepted at edge k+1 observes the status written at edge k.

**Asynchronous reset mid-multiply**
- Aborts immediately; the multiply result is never emitted.

## Structure
**Package `exe_pkg`**
- `exe_cmd` codes.
- Shift-type codes.
- Flag bit indices `N_BIT`..`V_BIT`.
- FSM state enum.

**Sub-modules**
- `exe_mul_iter`: parametrised shift-add multiplier with `start`, `busy`, `done` and `abort`.
- The shifter and the ALU stay inline as combinational functions.

## Test plan
- ADD, rn=0x7FFFFFFF, Val2=1, s=1 -> after 1 cycle `alu_res_o=0x80000000`, `status_o=1001` (N, V).
- SUB, rn=5, rm=5, s=1; then ADC rn=1, Val2=1 -> first gives 0 with Z=1, C=1; second gives 3.
- MUL 0x1234 × 0x10 with N=8 -> `in_ready` low 9 cycles, `alu_res_o=0x12340`, C and V unchanged.
- `out_ready=0` for 3 cycles with a result held -> outputs stable, `in_ready=0`, no instruction lost; release -> next op accepted.
- `flush` at cycle 4 of an MLA -> `out_valid` stays 0, status unchanged, next ADD accepted the following cycle.
- Branch, pc=0x100, imm24=0xFFFFFE -> `branch_addr_o=0xF8`, `branch_taken_o=1`. Then assert `rst` mid-MUL -> all outputs 0, no stale result after deassert.
